fcf_multilane_serializer: RTL and testbench

Parametrised successor to the fast-cluster-finder output serializer. Accepts WORD_W-bit cluster words from the cluster finder with a valid strobe, buffers them in a FIFO_DEPTH-entry FIFO, and ships each word MSB-first across N_LANES serial lanes, with one start bit per lane per frame. It adds three things the fixed two-line serializer did not have: configurable lane count, buffering with overflow detection, and back-to-back framing. The whole block runs on the fast serial clock.

---
 rtl/fcf_ser_if.sv | 27 ++
 rtl/fcf_multilane_serializer.sv | 127 ++++++++++++
 tb/tb_fcf_multilane_serializer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fcf_ser_if.sv
// Producer-side bus of the multilane serializer: cluster word input,
// module enable, and the serial/status outputs.
interface fcf_ser_if #(
    parameter int WORD_W     = 32,
    parameter int N_LANES    = 2,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                enable;
    logic [WORD_W-1:0]   data_in;
    logic                data_valid;
    logic [N_LANES-1:0]  data_out;
    logic                busy;
    logic [LVL_W-1:0]    fifo_level;
    logic                overflow;

    modport master (
        output enable, data_in, data_valid,
        input  data_out, busy, fifo_level, overflow
    );

    modport slave (
        input  enable, data_in, data_valid,
        output data_out, busy, fifo_level, overflow
    );
endinterface

// File: rtl/fcf_multilane_serializer.sv
// Buffers cluster words in a small FIFO and ships each one MSB-first over
// N_LANES serial lanes, one start bit per lane, frames back-to-back.
module fcf_multilane_serializer #(
    parameter int WORD_W     = 32,
    parameter int N_LANES    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       fs_clk,
    input  logic       reset_n,
    fcf_ser_if.slave   bus
);
    localparam int S     = WORD_W / N_LANES;
    localparam int CNT_W = $clog2(S + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_LANES-1:0]  dout_q, dout_d;
    logic                busy_q, busy_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];

    logic fifo_empty, fifo_full, frame_done, pop, push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        busy_d   = busy_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
        frame_done = (state_q == IDLE) || (cnt_q == '0);
        // A pop frees a slot on the same edge, so a full FIFO still accepts the write.
        pop  = bus.enable && !fifo_empty && frame_done;
        push = bus.enable && bus.data_valid && (!fifo_full || pop);

        if (!bus.enable) begin
            state_d  = IDLE;
            sh_d     = '0;
            cnt_d    = '0;
            dout_d   = '0;
            busy_d   = 1'b0;
            level_d  = '0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (bus.data_valid && fifo_full && !pop) ovf_d = 1'b1;
            if (push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);

            if (pop) begin
                sh_d    = mem_q[rd_ptr_q];
                dout_d  = '1;
                busy_d  = 1'b1;
                cnt_d   = CNT_W'(S);
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                if (cnt_q != '0) begin
                    for (int k = 0; k < N_LANES; k++) begin
                        dout_d[k]      = sh_q[k*S + S - 1];
                        sh_d[k*S +: S] = sh_q[k*S +: S] << 1;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    dout_d  = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge fs_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the word storage is not reset; the pointers and level alone decide what is valid.
    always_ff @(posedge fs_clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.data_in;
    end

    assign bus.data_out   = dout_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_fcf_multilane_serializer.sv
// Directed bench for the multilane serializer: a 2-lane and a 4-lane instance,
// with per-cycle lane values checked against a scoreboard queue.
module tb_fcf_multilane_serializer;
    logic fs_clk = 1'b0;
    logic rst1_n = 1'b0;
    logic rst2_n = 1'b0;
    always #5 fs_clk = ~fs_clk;

    fcf_ser_if #(.WORD_W(32), .N_LANES(2), .FIFO_DEPTH(4)) bus1();
    fcf_ser_if #(.WORD_W(32), .N_LANES(4), .FIFO_DEPTH(4)) bus2();

    fcf_multilane_serializer #(.WORD_W(32), .N_LANES(2), .FIFO_DEPTH(4)) dut1 (
        .fs_clk(fs_clk), .reset_n(rst1_n), .bus(bus1));
    fcf_multilane_serializer #(.WORD_W(32), .N_LANES(4), .FIFO_DEPTH(4)) dut2 (
        .fs_clk(fs_clk), .reset_n(rst2_n), .bus(bus2));

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp1[$];
    logic [3:0] exp2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Lane vector for frame cycle j: j=0 is the start bit, j=1..s are data bits MSB first.
    function automatic logic [3:0] lane_vec(input int n, input logic [31:0] w, input int j);
        int s = 32 / n;
        logic [3:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = (j == 0) ? 1'b1 : w[k*s + s - j];
        return v;
    endfunction

    task automatic expect1(input logic [31:0] w);
        for (int j = 0; j <= 16; j++) exp1.push_back(lane_vec(2, w, j));
    endtask

    task automatic expect2(input logic [31:0] w);
        for (int j = 0; j <= 8; j++) exp2.push_back(lane_vec(4, w, j));
    endtask

    task automatic tick();
        @(posedge fs_clk);
        #1;
    endtask

    task automatic write1(input logic [31:0] w, input bit accepted);
        bus1.data_in    = w;
        bus1.data_valid = 1'b1;
        if (accepted) expect1(w);
        tick();
        bus1.data_valid = 1'b0;
    endtask

    task automatic write2(input logic [31:0] w);
        bus2.data_in    = w;
        bus2.data_valid = 1'b1;
        expect2(w);
        tick();
        bus2.data_valid = 1'b0;
    endtask

    task automatic wait_idle1(input int budget);
        int n = 0;
        while (bus1.busy && n < budget) begin
            tick();
            n++;
        end
        check("idle1_reached", 32'(bus1.busy), 32'd0);
    endtask

    // Monitors: every busy cycle pops one expected lane vector; idle cycles must be all-zero.
    always @(negedge fs_clk) begin
        if (rst1_n) begin
            if (bus1.busy) begin
                if (exp1.size() == 0) check("lanes1_queue_nonempty", 32'd0, 32'd1);
                else check("lanes1", 32'(bus1.data_out), 32'(exp1.pop_front()));
            end else begin
                check("idle1_zero", 32'(bus1.data_out), 32'd0);
            end
        end
    end

    always @(negedge fs_clk) begin
        if (rst2_n) begin
            if (bus2.busy) begin
                if (exp2.size() == 0) check("lanes2_queue_nonempty", 32'd0, 32'd1);
                else check("lanes2", 32'(bus2.data_out), 32'(exp2.pop_front()));
            end else begin
                check("idle2_zero", 32'(bus2.data_out), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int nb;
        logic [16:0] c1, c0;
        logic [7:0]  d3, d0;
        int lv[6]   = '{1, 1, 2, 3, 4, 4};
        bit ovf[6]  = '{0, 0, 0, 0, 0, 1};
        logic [31:0] ow[6] = '{32'h11112222, 32'h33334444, 32'h55556666,
                               32'h77778888, 32'h9999AAAA, 32'hBBBBCCCC};

        bus1.enable = 1'b1; bus1.data_valid = 1'b0; bus1.data_in = '0;
        bus2.enable = 1'b1; bus2.data_valid = 1'b0; bus2.data_in = '0;
        #23;
        check("rst_data_out", 32'(bus1.data_out), 32'd0);
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_level", 32'(bus1.fifo_level), 32'd0);
        check("rst_overflow", 32'(bus1.overflow), 32'd0);
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        tick();

        // Single word, latency and exact lane bit strings.
        write1(32'hA5A53C3C, 1'b1);
        check("t1_no_bypass_busy", 32'(bus1.busy), 32'd0);
        check("t1_level_after_write", 32'(bus1.fifo_level), 32'd1);
        tick();
        check("t1_start_bits", 32'(bus1.data_out), 32'h3);
        check("t1_level_after_pop", 32'(bus1.fifo_level), 32'd0);
        nb = 0; c1 = '0; c0 = '0;
        while (bus1.busy && nb < 40) begin
            c1 = {c1[15:0], bus1.data_out[1]};
            c0 = {c0[15:0], bus1.data_out[0]};
            nb++;
            tick();
        end
        check("t1_busy_cycles", 32'(nb), 32'd17);
        check("t1_lane1_bits", 32'(c1), 32'h1A5A5);
        check("t1_lane0_bits", 32'(c0), 32'h13C3C);
        check("t1_out_after", 32'(bus1.data_out), 32'd0);
        repeat (3) tick();

        // Back-to-back frames.
        write1(32'hFFFF0000, 1'b1);
        check("t2_level_a", 32'(bus1.fifo_level), 32'd1);
        write1(32'h0000FFFF, 1'b1);
        check("t2_level_b", 32'(bus1.fifo_level), 32'd1);
        nb = 0;
        while (bus1.busy && nb < 80) begin
            nb++;
            tick();
        end
        check("t2_contiguous_busy", 32'(nb), 32'd35 - 32'd1);
        check("t2_level_end", 32'(bus1.fifo_level), 32'd0);
        repeat (3) tick();

        // Six writes into depth 4: sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            write1(ow[i], i < 5);
            check("t3_level", 32'(bus1.fifo_level), 32'(lv[i]));
            check("t3_overflow", 32'(bus1.overflow), 32'(ovf[i]));
        end
        wait_idle1(200);
        check("t3_overflow_sticky", 32'(bus1.overflow), 32'd1);
        bus1.enable = 1'b0;
        bus1.data_valid = 1'b1;
        bus1.data_in = 32'hDEADBEEF;
        tick();
        check("t3_overflow_cleared", 32'(bus1.overflow), 32'd0);
        check("t3_level_cleared", 32'(bus1.fifo_level), 32'd0);
        bus1.data_valid = 1'b0;
        bus1.enable = 1'b1;
        tick();
        check("t3_disabled_write_ignored", 32'(bus1.fifo_level), 32'd0);

        // Full FIFO, pop and write on the same edge.
        for (int i = 0; i < 5; i++) write1(32'h01020304 * (i + 1), 1'b1);
        repeat (13) tick();
        check("t4_full_before", 32'(bus1.fifo_level), 32'd4);
        write1(32'hC0FFEE00, 1'b1);
        check("t4_level_held", 32'(bus1.fifo_level), 32'd4);
        check("t4_no_overflow", 32'(bus1.overflow), 32'd0);
        wait_idle1(200);
        repeat (2) tick();

        // Enable dropped at data bit 5 with two words queued.
        write1(32'h87654321, 1'b1);
        write1(32'h0F0F0F0F, 1'b1);
        write1(32'hF0F0F0F0, 1'b1);
        check("t5_level_queued", 32'(bus1.fifo_level), 32'd2);
        repeat (5) tick();
        check("t5_busy_mid", 32'(bus1.busy), 32'd1);
        bus1.enable = 1'b0;
        tick();
        exp1.delete();
        check("t5_out_flushed", 32'(bus1.data_out), 32'd0);
        check("t5_busy_flushed", 32'(bus1.busy), 32'd0);
        check("t5_level_flushed", 32'(bus1.fifo_level), 32'd0);
        bus1.enable = 1'b1;
        repeat (30) tick();
        check("t5_no_resume_busy", 32'(bus1.busy), 32'd0);
        check("t5_no_resume_level", 32'(bus1.fifo_level), 32'd0);

        // Four lanes: 9-cycle frame, then async reset mid-frame.
        write2(32'h12345678);
        tick();
        check("t6_start_bits", 32'(bus2.data_out), 32'hF);
        nb = 0; d3 = '0; d0 = '0;
        while (bus2.busy && nb < 20) begin
            if (nb > 0) begin
                d3 = {d3[6:0], bus2.data_out[3]};
                d0 = {d0[6:0], bus2.data_out[0]};
            end
            nb++;
            tick();
        end
        check("t6_busy_cycles", 32'(nb), 32'd9);
        check("t6_lane3_byte", 32'(d3), 32'h12);
        check("t6_lane0_byte", 32'(d0), 32'h78);
        repeat (2) tick();
        write2(32'hCAFEBABE);
        repeat (4) tick();
        check("t6_busy_before_reset", 32'(bus2.busy), 32'd1);
        #2;
        rst2_n = 1'b0;
        #1;
        check("t6_async_out", 32'(bus2.data_out), 32'd0);
        check("t6_async_busy", 32'(bus2.busy), 32'd0);
        check("t6_async_level", 32'(bus2.fifo_level), 32'd0);
        exp2.delete();
        #3;
        rst2_n = 1'b1;
        repeat (12) tick();
        check("t6_idle_after_reset", 32'(bus2.busy), 32'd0);

        check("exp1_drained", 32'(exp1.size()), 32'd0);
        check("exp2_drained", 32'(exp2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
